video_timing_gen: RTL and testbench

Pixel-clock video source that feeds the HDMI transmit path. It generates the horizontal and vertical counters for one video mode, the sync and data-enable strobes, and a selectable test pattern. All outputs are registered and mutually aligned, and connect directly to the transmitter's `i_rgb_data`, `i_hsync`, `i_vsync` and `i_de` inputs. A frame-start pulse and pixel coordinates are also exported for downstream overlay logic.

---
 rtl/video_timing_gen.sv | 127 ++++++++++++
 tb/tb_video_timing_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Video timing generator: free-running h/v counters, sync and data-enable strobes,
// and a frame-shadowed test-pattern source. Every output is registered on the same pixel.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        i_pixclk,
    input  logic        i_reset,
    input  logic [1:0]  i_pattern,
    input  logic [23:0] i_solid_rgb,
    output logic [23:0] o_rgb_data,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_start,
    output logic [11:0] o_x,
    output logic [11:0] o_y
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Tiny modes would give a zero bar width; clamp so the divide stays defined.
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_DIV = 12'(BAR_W);

    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
        24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000
    };

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [1:0]  pat_q;
    logic [23:0] solid_q;
    logic [23:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic [11:0] x_q, y_q;
    logic        h_wrap, v_wrap;
    logic [11:0] bar_raw;
    logic [2:0]  bar_idx;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
        end

        de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        fs_d    = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

        bar_raw = h_cnt_q / BAR_DIV;
        bar_idx = (bar_raw > 12'd7) ? 3'd7 : bar_raw[2:0];

        rgb_d = 24'h000000;
        if (de_d) begin
            case (pat_q)
                2'd0:    rgb_d = BAR_RGB[bar_idx];
                2'd1:    rgb_d = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
                2'd2:    rgb_d = solid_q;
                default: rgb_d = {3{h_cnt_q[7:0]}};
            endcase
        end
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            rgb_q   <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            // Select inputs only take effect at a frame boundary.
            if (h_wrap && v_wrap) begin
                pat_q   <= i_pattern;
                solid_q <= i_solid_rgb;
            end
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            x_q     <= h_cnt_q;
            y_q     <= v_cnt_q;
        end
    end

    assign o_rgb_data    = rgb_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 mode, a reduced 320x34 mode for frame-level behaviour,
// and the tiny 4x3 mode for exact timing.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]  d_pat, m_pat, s_pat;
    logic [23:0] d_solid, m_solid, s_solid;
    logic [23:0] d_rgb, m_rgb, s_rgb;
    logic        d_hs, d_vs, d_de, d_fs;
    logic        m_hs, m_vs, m_de, m_fs;
    logic        s_hs, s_vs, s_de, s_fs;
    logic [11:0] d_x, d_y, m_x, m_y, s_x, s_y;

    video_timing_gen u_def (
        .i_pixclk(clk), .i_reset(rst), .i_pattern(d_pat), .i_solid_rgb(d_solid),
        .o_rgb_data(d_rgb), .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de),
        .o_frame_start(d_fs), .o_x(d_x), .o_y(d_y)
    );

    video_timing_gen #(
        .H_ACTIVE(320), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_med (
        .i_pixclk(clk), .i_reset(rst), .i_pattern(m_pat), .i_solid_rgb(m_solid),
        .o_rgb_data(m_rgb), .o_hsync(m_hs), .o_vsync(m_vs), .o_de(m_de),
        .o_frame_start(m_fs), .o_x(m_x), .o_y(m_y)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .i_pixclk(clk), .i_reset(rst), .i_pattern(s_pat), .i_solid_rgb(s_solid),
        .o_rgb_data(s_rgb), .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de),
        .o_frame_start(s_fs), .o_x(s_x), .o_y(s_y)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto_med(input int x, input int y);
        int n;
        n = 0;
        while (!(m_x == 12'(x) && m_y == 12'(y)) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            errors++;
            $display("FAIL goto_med (%0d,%0d): stuck at (%0d,%0d)", x, y, m_x, m_y);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (100) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (d_de !== 1'b0 || d_rgb !== 24'h0 || d_hs !== 1'b1 || d_vs !== 1'b1 || d_fs !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: de=%b rgb=%06h hs=%b vs=%b fs=%b, expected 0 000000 1 1 0",
                     d_de, d_rgb, d_hs, d_vs, d_fs);
        end
        checks++;
        if (d_x !== 12'd0 || d_y !== 12'd0) begin
            errors++;
            $display("FAIL reset_xy: x=%0d y=%0d, expected 0 0", d_x, d_y);
        end
        repeat (5) tick();
        checks++;
        if (d_de !== 1'b0 || d_hs !== 1'b1 || d_vs !== 1'b1 || m_de !== 1'b0 || s_de !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: de=%b hs=%b vs=%b mde=%b sde=%b, expected 0 1 1 0 0",
                     d_de, d_hs, d_vs, m_de, s_de);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (d_de !== 1'b1 || d_fs !== 1'b1 || d_x !== 12'd0 || d_y !== 12'd0 || d_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL first_pixel: de=%b fs=%b x=%0d y=%0d rgb=%06h, expected 1 1 0 0 FFFFFF",
                     d_de, d_fs, d_x, d_y, d_rgb);
        end
        checks++;
        if (m_fs !== 1'b1 || m_x !== 12'd0 || s_fs !== 1'b1 || s_x !== 12'd0) begin
            errors++;
            $display("FAIL first_pixel_other: mfs=%b mx=%0d sfs=%b sx=%0d, expected 1 0 1 0",
                     m_fs, m_x, s_fs, s_x);
        end
    endtask

    task automatic test_colour_bars();
        int xs [7];
        logic [23:0] exp_rgb [7];
        int n;
        xs      = '{0, 79, 80, 399, 480, 639, 640};
        exp_rgb = '{24'hFFFFFF, 24'hFFFFFF, 24'h00FFFF, 24'hFF00FF, 24'hFF0000, 24'h000000, 24'h000000};
        for (int k = 0; k < 7; k++) begin
            n = 0;
            while (d_x != 12'(xs[k]) && n < 1000) begin
                tick();
                n++;
            end
            checks++;
            if (d_y !== 12'd0 || d_x !== 12'(xs[k]) || d_rgb !== exp_rgb[k]) begin
                errors++;
                $display("FAIL bars x=%0d: got (%0d,%0d) rgb=%06h, expected rgb %06h on line 0",
                         xs[k], d_x, d_y, d_rgb, exp_rgb[k]);
            end
        end
    endtask

    task automatic test_line_timing();
        int n, de_n, hs_n, hs_at;
        n = 0;
        while (!(d_de === 1'b1 && d_x == 12'd0) && n < 1000) begin
            tick();
            n++;
        end
        for (int ln = 0; ln < 2; ln++) begin
            de_n = 0; hs_n = 0; hs_at = -1;
            for (int t = 0; t < 800; t++) begin
                if (d_de) de_n++;
                if (!d_hs) begin
                    hs_n++;
                    if (hs_at < 0) hs_at = t;
                end
                tick();
            end
            checks++;
            if (de_n != 640) begin
                errors++;
                $display("FAIL line%0d_de_width: got %0d, expected 640", ln, de_n);
            end
            checks++;
            if (hs_n != 96 || hs_at != 656) begin
                errors++;
                $display("FAIL line%0d_hsync: width %0d start %0d, expected 96 656", ln, hs_n, hs_at);
            end
            checks++;
            if (d_de !== 1'b1 || d_x !== 12'd0 || d_vs !== 1'b1) begin
                errors++;
                $display("FAIL line%0d_period: de=%b x=%0d vs=%b after 800, expected 1 0 1", ln, d_de, d_x, d_vs);
            end
        end
    endtask

    task automatic test_small_mode();
        int n, ex, ey, de_err, hs_err, vs_err, xy_err, fs_err, de_total;
        n = 0;
        while (s_fs !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        de_err = 0; hs_err = 0; vs_err = 0; xy_err = 0; fs_err = 0; de_total = 0;
        for (int c = 0; c < 48; c++) begin
            ex = c % 8;
            ey = c / 8;
            if (s_de !== ((ex < 4) && (ey < 3))) de_err++;
            if (s_hs !== !((ex >= 5) && (ex <= 6))) hs_err++;
            if (s_vs !== (ey != 4)) vs_err++;
            if (s_x !== 12'(ex) || s_y !== 12'(ey)) xy_err++;
            if (s_fs !== (c == 0)) fs_err++;
            if (s_de) de_total++;
            tick();
        end
        checks++;
        if (de_err != 0 || de_total != 12) begin
            errors++;
            $display("FAIL small_de: %0d wrong cycles, %0d high, expected 0 wrong 12 high", de_err, de_total);
        end
        checks++;
        if (hs_err != 0) begin
            errors++;
            $display("FAIL small_hsync: %0d wrong cycles, expected 0", hs_err);
        end
        checks++;
        if (vs_err != 0) begin
            errors++;
            $display("FAIL small_vsync: %0d wrong cycles, expected 0", vs_err);
        end
        checks++;
        if (xy_err != 0) begin
            errors++;
            $display("FAIL small_xy: %0d wrong cycles, expected 0", xy_err);
        end
        checks++;
        if (fs_err != 0 || s_fs !== 1'b1) begin
            errors++;
            $display("FAIL small_frame_period: %0d stray, fs at 48 = %b, expected 0 and 1", fs_err, s_fs);
        end
    endtask

    task automatic test_shadowed_select();
        int xs [4];
        logic [23:0] exp_rgb [4];
        int n, act, bad, blank_bad;
        goto_med(0, 20);
        m_pat   = 2'd2;
        m_solid = 24'h123456;
        xs      = '{0, 60, 100, 300};
        exp_rgb = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h000000};
        for (int k = 0; k < 4; k++) begin
            goto_med(xs[k], 25);
            checks++;
            if (m_rgb !== exp_rgb[k]) begin
                errors++;
                $display("FAIL shadow_hold x=%0d: rgb=%06h, expected %06h", xs[k], m_rgb, exp_rgb[k]);
            end
        end
        goto_med(0, 0);
        checks++;
        if (m_rgb !== 24'h123456 || m_fs !== 1'b1) begin
            errors++;
            $display("FAIL shadow_apply: rgb=%06h fs=%b, expected 123456 1", m_rgb, m_fs);
        end
        n = 0; act = 0; bad = 0; blank_bad = 0;
        do begin
            if (m_de) begin
                act++;
                if (m_rgb !== 24'h123456) bad++;
            end else if (m_rgb !== 24'h0) begin
                blank_bad++;
            end
            tick();
            n++;
            m_pat = 2'd1;
        end while (m_fs !== 1'b1 && n < 20000);
        checks++;
        if (bad != 0 || act != 10880) begin
            errors++;
            $display("FAIL shadow_frame: %0d wrong of %0d active, expected 0 of 10880", bad, act);
        end
        checks++;
        if (blank_bad != 0) begin
            errors++;
            $display("FAIL blanking_rgb: %0d nonzero blank pixels, expected 0", blank_bad);
        end
    endtask

    task automatic test_checker_and_ramp();
        int xs [8];
        int ys [8];
        logic [23:0] exp_rgb [8];
        xs      = '{0, 32, 0, 32, 5, 255, 256, 300};
        ys      = '{0, 0, 32, 32, 0, 10, 10, 10};
        exp_rgb = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000,
                    24'h050505, 24'hFFFFFF, 24'h000000, 24'h2C2C2C};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                m_pat = 2'd3;
                goto_med(0, 0);
            end
            goto_med(xs[k], ys[k]);
            checks++;
            if (m_rgb !== exp_rgb[k] || m_de !== 1'b1) begin
                errors++;
                $display("FAIL pattern%0d (%0d,%0d): rgb=%06h de=%b, expected %06h 1",
                         (k < 4) ? 1 : 3, xs[k], ys[k], m_rgb, m_de, exp_rgb[k]);
            end
        end
    endtask

    task automatic test_frame_timing();
        int n, vs_n, vs_x, vs_y, de_total;
        goto_med(326, 37);
        m_pat   = 2'd2;
        m_solid = 24'hABCDEF;
        tick();
        tick();
        checks++;
        if (m_x !== 12'd0 || m_y !== 12'd0 || m_fs !== 1'b1 || m_rgb !== 24'hABCDEF) begin
            errors++;
            $display("FAIL last_pixel_load: (%0d,%0d) fs=%b rgb=%06h, expected (0,0) 1 ABCDEF",
                     m_x, m_y, m_fs, m_rgb);
        end
        n = 0; vs_n = 0; vs_x = -1; vs_y = -1; de_total = 0;
        do begin
            if (!m_vs) begin
                if (vs_n == 0) begin
                    vs_x = int'(m_x);
                    vs_y = int'(m_y);
                end
                vs_n++;
            end
            if (m_de) de_total++;
            tick();
            n++;
        end while (m_fs !== 1'b1 && n < 20000);
        checks++;
        if (n != 12464) begin
            errors++;
            $display("FAIL frame_period: got %0d, expected 12464", n);
        end
        checks++;
        if (vs_n != 656 || vs_x != 0 || vs_y != 35) begin
            errors++;
            $display("FAIL vsync: %0d cycles from (%0d,%0d), expected 656 from (0,35)", vs_n, vs_x, vs_y);
        end
        checks++;
        if (de_total != 10880) begin
            errors++;
            $display("FAIL frame_de: got %0d, expected 10880", de_total);
        end
    endtask

    initial begin
        d_pat = 2'd2; d_solid = 24'h00AB00;
        m_pat = 2'd0; m_solid = 24'h0;
        s_pat = 2'd0; s_solid = 24'h0;
        test_reset();
        test_colour_bars();
        test_line_timing();
        test_small_mode();
        test_shadowed_select();
        test_checker_and_ramp();
        test_frame_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
